// File: rtl/idu_dispatch_queue_pkg.sv
// idu_dispatch_queue_pkg: shared widths, queue depth and entry type for the IDU dispatch queue.
package idu_dispatch_queue_pkg;
  localparam int PC_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int SUPER_SCALAR_NUM = 2;
  localparam int DISP_QUEUE_DEPTH = 8;
  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [DATA_WIDTH-1:0] inst;
  } disp_entry_t;
endpackage

// File: rtl/idu_dispatch_queue.sv
// idu_dispatch_queue: two-wide in-order fetch buffer with show-ahead issue, stall hold and flush.
// Optional DISP_PERF_CNT_EN adds a saturating stall counter port.
module idu_dispatch_queue
  import idu_dispatch_queue_pkg::*;
#(
  parameter int DEPTH = DISP_QUEUE_DEPTH
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [SUPER_SCALAR_NUM-1:0]            i_ifu_disp_vld,
  input  logic [SUPER_SCALAR_NUM*PC_WIDTH-1:0]   i_ifu_disp_pc,
  input  logic [SUPER_SCALAR_NUM*DATA_WIDTH-1:0] i_ifu_disp_inst,
  output logic                                   o_disp_ifu_rdy,
  input  logic                                   i_idu_dispatcher_stall_vld,
  input  logic                                   i_iex_disp_flush,
  output logic [SUPER_SCALAR_NUM-1:0]            o_disp_idu_vld,
  output logic [SUPER_SCALAR_NUM*PC_WIDTH-1:0]   o_disp_idu_pc,
  output logic [SUPER_SCALAR_NUM*DATA_WIDTH-1:0] o_disp_idu_inst
`ifdef DISP_PERF_CNT_EN
  ,
  output logic [31:0]                            o_disp_perf_stall_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] RDY_MAX = (AW+1)'(DEPTH - 2);
  disp_entry_t r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr, w_wr_ptr1, w_rd_ptr1;
  logic [AW:0] r_count;
  logic [1:0] w_push_n, w_pop_n;
  disp_entry_t w_wr0, w_wr1, w_s0, w_s1;
  assign o_disp_ifu_rdy = r_count <= RDY_MAX;
  assign w_wr_ptr1 = r_wr_ptr + 1'b1;
  assign w_rd_ptr1 = r_rd_ptr + 1'b1;
  assign w_push_n = (o_disp_ifu_rdy && !i_iex_disp_flush) ?
                    {1'b0, i_ifu_disp_vld[0]} + {1'b0, i_ifu_disp_vld[1]} : 2'd0;
  assign o_disp_idu_vld = (r_count >= 2) ? 2'b11 : (r_count == 1) ? 2'b01 : 2'b00;
  assign w_pop_n = (i_idu_dispatcher_stall_vld || i_iex_disp_flush) ? 2'd0 :
                   {1'b0, o_disp_idu_vld[0]} + {1'b0, o_disp_idu_vld[1]};
  // A lone lane-1 instruction compacts into the wr_ptr slot
  assign w_wr0 = i_ifu_disp_vld[0] ? {i_ifu_disp_pc[PC_WIDTH-1:0], i_ifu_disp_inst[DATA_WIDTH-1:0]}
                                   : {i_ifu_disp_pc[PC_WIDTH +: PC_WIDTH], i_ifu_disp_inst[DATA_WIDTH +: DATA_WIDTH]};
  assign w_wr1 = {i_ifu_disp_pc[PC_WIDTH +: PC_WIDTH], i_ifu_disp_inst[DATA_WIDTH +: DATA_WIDTH]};
  assign w_s0 = r_mem[r_rd_ptr];
  assign w_s1 = r_mem[w_rd_ptr1];
  assign o_disp_idu_pc[PC_WIDTH-1:0] = o_disp_idu_vld[0] ? w_s0.pc : '0;
  assign o_disp_idu_pc[PC_WIDTH +: PC_WIDTH] = o_disp_idu_vld[1] ? w_s1.pc : '0;
  assign o_disp_idu_inst[DATA_WIDTH-1:0] = o_disp_idu_vld[0] ? w_s0.inst : '0;
  assign o_disp_idu_inst[DATA_WIDTH +: DATA_WIDTH] = o_disp_idu_vld[1] ? w_s1.inst : '0;
  always_ff @(posedge clk) begin
    if (w_push_n != 2'd0) r_mem[r_wr_ptr] <= w_wr0;
    if (w_push_n == 2'd2) r_mem[w_wr_ptr1] <= w_wr1;
  end
  always_ff @(posedge clk) begin
    if (rst || i_iex_disp_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_push_n);
      r_rd_ptr <= r_rd_ptr + AW'(w_pop_n);
      r_count <= r_count + (AW+1)'(w_push_n) - (AW+1)'(w_pop_n);
    end
  end
`ifdef DISP_PERF_CNT_EN
  logic [31:0] r_perf_cnt;
  always_ff @(posedge clk) begin
    if (rst) r_perf_cnt <= '0;
    else if (i_idu_dispatcher_stall_vld && |o_disp_idu_vld && !i_iex_disp_flush && !(&r_perf_cnt))
      r_perf_cnt <= r_perf_cnt + 32'd1;
  end
  assign o_disp_perf_stall_cnt = r_perf_cnt;
`endif
endmodule

// File: doc/idu_dispatch_queue.md
# idu_dispatch_queue

Two-wide in-order instruction queue between IFU fetch output and the IDU decode/bypass stage. Buffers up to DEPTH fetched (pc, inst) pairs, presents the two oldest to the IDU each cycle, and holds them while the bypass MUX raises `idu_dispatcher_stall_vld`. A branch/jump redirect from IEX flushes all buffered instructions.

## Interface
- `DEPTH`, 8: entry count; power of two, ≥4.
- `LANES`, `SUPER_SCALAR_NUM` (2): instructions pushed/issued per cycle; fixed at 2.
- `clk` in 1: one clock; reset is synchronous and active-high.
- `rst` in 1: synchronous active-high reset.
- `ifu_disp_vld` in [1:0]: per-lane fetch valid; lane 0 is older.
- `ifu_disp_pc` in [`PC_WIDTH-1:0] ×2: lane PCs.
- `ifu_disp_inst` in [`DATA_WIDTH-1:0] ×2: lane instruction words.
- `disp_ifu_rdy` out 1: queue can accept two instructions this cycle.
- `idu_dispatcher_stall_vld` in 1: IDU cannot consume this cycle.
- `iex_disp_flush` in 1: redirect; discard all queued instructions.
- `disp_idu_vld` out [1:0]: issue-slot valid; slot 0 is oldest.
- `disp_idu_pc` out [`PC_WIDTH-1:0] ×2, `disp_idu_inst` out [`DATA_WIDTH-1:0] ×2: issue-slot payload.
- `disp_perf_stall_cnt` out [31:0]: only with `DISP_PERF_CNT_EN`.

## Operation
- Storage: circular buffer of DEPTH entries; `wr_ptr`, `rd_ptr` of log2(DEPTH) bits, wrap modulo DEPTH; `count` of log2(DEPTH)+1 bits.
- `disp_ifu_rdy = (count <= DEPTH-2)`, computed from registered count, independent of same-cycle pop.
- Push (when `disp_ifu_rdy` and not flush): number of pushed entries = popcount(`ifu_disp_vld`). Pattern 2'b11 writes lane0 at `wr_ptr`, lane1 at `wr_ptr+1`. Pattern 2'b01 or 2'b10 compacts: the single valid lane is written at `wr_ptr`. Push while `!disp_ifu_rdy` is dropped (IFU protocol violation; bench asserts never).
- Issue view (show-ahead, combinational from storage): slot0 = entry[`rd_ptr`], slot1 = entry[`rd_ptr+1`]. `disp_idu_vld = count≥2 ? 2'b11 : count==1 ? 2'b01 : 2'b00`. Invalid slots drive pc/inst = 0.
- Pop: when `!idu_dispatcher_stall_vld` and not flush, `rd_ptr += popcount(disp_idu_vld)`. Stall holds both slots and their payload unchanged.
- Count update: `count_next = count + pushed - popped`; simultaneous push and pop both apply.
- Flush: `rd_ptr`, `wr_ptr`, `count` → 0; same-cycle push and pop ignored. Flush has priority over everything except `rst`.
- Reset: pointers and count 0; hence `disp_idu_vld = 0`, payload 0, `disp_ifu_rdy = 1`, perf counter 0. Reset mid-operation discards contents identically to flush.
- Storage array is not reset; only pointers and count are.

## Timing
- Push-to-issue latency: 1 cycle (written at edge N, visible on `disp_idu_*` during cycle N+1).
- Pop takes effect at the edge ending the cycle in which `!stall`; next slots visible the following cycle.
- Flush asserted in cycle N: `disp_idu_vld = 0` from cycle N+1; IFU push in N+1 accepted normally.
- Boundaries: count = DEPTH-1 → rdy low even if a pop occurs that cycle; count = DEPTH-2 plus 2-wide push and no pop → full, rdy low next cycle; pointer wrap from DEPTH-1 to 0 with slot1 at index 0 must read correctly.

## Configuration
- `DISP_PERF_CNT_EN` defined: `disp_perf_stall_cnt` port and a 32-bit counter exist; increments each cycle `idu_dispatcher_stall_vld && disp_idu_vld != 0 && !iex_disp_flush`; saturates at 32'hFFFF_FFFF; cleared only by `rst`.
- Undefined: port and counter absent; behaviour otherwise identical.

## Structure
- Shared package/define file: `PC_WIDTH`, `DATA_WIDTH`, `SUPER_SCALAR_NUM`; add `DISP_QUEUE_DEPTH` define and a packed typedef `disp_entry_t {pc, inst}`.
- No sub-module; a single module with storage array, pointer logic and optional counter.

## Test plan
- Reset, then push 2'b11 (pc 0x1000/0x1004) → next cycle `disp_idu_vld`=2'b11, pcs 0x1000/0x1004; no stall → following cycle vld=2'b00.
- Push 3 instructions with stall held 4 cycles → slots hold 0x1000/0x1004 for all 4 cycles; release → next cycle slot0=0x1008, vld=2'b01.
- Fill DEPTH=8 under stall → `disp_ifu_rdy` low at count 7 and 8; push attempt while low leaves count unchanged.
- Pointer wrap: with `rd_ptr`=7, count=2 → slot0 from entry 7, slot1 from entry 0, correct pcs.
- Flush with count=5 plus same-cycle push 2'b11 → next cycle vld=2'b00, rdy=1, count 0.
- With `DISP_PERF_CNT_EN`: 3 stalled cycles with valid slots plus 2 stalled cycles with empty queue → `disp_perf_stall_cnt` = 3.
